// File: rtl/err_inject_ctrl.sv
// Error-insertion sequencer for the BERT transmit path: picks which valid words
// get a single bit flipped (single / periodic / random / burst) and counts them.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no session; words pass clean, waiting for start
// ARM   | one settling cycle after start; burst gap timer loaded
// RUN   | counting valid words, injecting per the latched mode
// BURST | corrupting every valid word until burst_len are done
module err_inject_ctrl #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [CNT_W-1:0]  period,
    input  logic [7:0]        burst_len,
    input  logic [DATA_W-1:0] threshold,
    input  logic [CNT_W-1:0]  target,
    input  logic [DATA_W-1:0] rnd,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              inj_pulse,
    output logic [CNT_W-1:0]  err_total,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_RUN   = 2'd2,
        S_BURST = 2'd3
    } state_t;

    localparam logic [1:0]        MODE_SINGLE   = 2'b00;
    localparam logic [1:0]        MODE_PERIODIC = 2'b01;
    localparam logic [1:0]        MODE_RANDOM   = 2'b10;
    localparam logic [1:0]        MODE_BURST    = 2'b11;
    localparam logic [DATA_W-1:0] DW            = DATA_W'(DATA_W);
    localparam logic [DATA_W-1:0] ONE_HOT0      = {{(DATA_W-1){1'b0}}, 1'b1};

    state_t            state, state_nxt;
    logic [1:0]        mode_q;
    logic [CNT_W-1:0]  period_q;
    logic [7:0]        burst_len_q;
    logic [DATA_W-1:0] threshold_q;
    logic [CNT_W-1:0]  target_q;

    logic [CNT_W-1:0]  word_cnt, word_cnt_nxt;
    logic [CNT_W-1:0]  gap_cnt, gap_cnt_nxt;
    logic [7:0]        burst_cnt, burst_cnt_nxt;

    logic              latch_cfg;
    logic              inject;
    logic              done_nxt;
    logic [CNT_W-1:0]  err_inc;
    logic [DATA_W-1:0] bit_idx;
    logic [DATA_W-1:0] mask;

    assign busy    = (state != S_IDLE);
    assign err_inc = (err_total == {CNT_W{1'b1}}) ? err_total : err_total + 1'b1;
    assign bit_idx = rnd % DW;
    assign mask    = inject ? (ONE_HOT0 << bit_idx) : '0;

    always_comb begin
        state_nxt     = state;
        latch_cfg     = 1'b0;
        inject        = 1'b0;
        done_nxt      = 1'b0;
        word_cnt_nxt  = word_cnt;
        gap_cnt_nxt   = gap_cnt;
        burst_cnt_nxt = burst_cnt;

        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    latch_cfg = 1'b1;
                    state_nxt = S_ARM;
                end
            end
            S_ARM: begin
                state_nxt = S_RUN;
                if (mode_q == MODE_BURST)
                    gap_cnt_nxt = period_q;
            end
            S_RUN: begin
                if (in_valid) begin
                    case (mode_q)
                        MODE_SINGLE: begin
                            inject    = 1'b1;
                            state_nxt = S_IDLE;
                            done_nxt  = 1'b1;
                        end
                        MODE_PERIODIC: begin
                            if (word_cnt + 1'b1 == period_q) begin
                                inject       = 1'b1;
                                word_cnt_nxt = '0;
                            end else begin
                                word_cnt_nxt = word_cnt + 1'b1;
                            end
                        end
                        MODE_RANDOM: inject = (rnd < threshold_q);
                        default: begin
                            // terminal count: this valid word completes the gap
                            if (gap_cnt <= 1) begin
                                state_nxt     = S_BURST;
                                burst_cnt_nxt = '0;
                            end else begin
                                gap_cnt_nxt = gap_cnt - 1'b1;
                            end
                        end
                    endcase
                end
            end
            S_BURST: begin
                if (in_valid) begin
                    inject = 1'b1;
                    if (burst_cnt + 8'd1 == burst_len_q) begin
                        state_nxt   = S_RUN;
                        gap_cnt_nxt = period_q;
                    end else begin
                        burst_cnt_nxt = burst_cnt + 8'd1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        if (inject && (target_q != '0) && (err_inc == target_q)) begin
            state_nxt = S_IDLE;
            done_nxt  = 1'b1;
        end

        // abort beats both completion and a pending injection on this word
        if (abort && (state != S_IDLE)) begin
            state_nxt = S_IDLE;
            done_nxt  = 1'b1;
            inject    = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            mode_q      <= '0;
            period_q    <= '0;
            burst_len_q <= '0;
            threshold_q <= '0;
            target_q    <= '0;
            word_cnt    <= '0;
            gap_cnt     <= '0;
            burst_cnt   <= '0;
            err_total   <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            inj_pulse   <= 1'b0;
            done        <= 1'b0;
        end else begin
            state     <= state_nxt;
            out_valid <= in_valid;
            out_data  <= in_data ^ mask;
            inj_pulse <= inject;
            done      <= done_nxt;
            if (latch_cfg) begin
                mode_q      <= mode;
                period_q    <= (period == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : period;
                burst_len_q <= (burst_len == 8'd0) ? 8'd1 : burst_len;
                threshold_q <= threshold;
                target_q    <= target;
                word_cnt    <= '0;
                gap_cnt     <= '0;
                burst_cnt   <= '0;
                err_total   <= '0;
            end else begin
                word_cnt  <= word_cnt_nxt;
                gap_cnt   <= gap_cnt_nxt;
                burst_cnt <= burst_cnt_nxt;
                if (inject)
                    err_total <= err_inc;
            end
        end
    end

endmodule

// File: tb/tb_err_inject_ctrl.sv
// Directed bench for err_inject_ctrl: each mode, stalls, abort, clamping and
// mid-session reset, with hand-computed expected words.
module tb_err_inject_ctrl;

    logic        clock;
    logic        reset;
    logic        start;
    logic        abort;
    logic [1:0]  mode;
    logic [15:0] period;
    logic [7:0]  burst_len;
    logic [7:0]  threshold;
    logic [15:0] target;
    logic [7:0]  rnd;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        inj_pulse;
    logic [15:0] err_total;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    err_inject_ctrl #(.DATA_W(8), .CNT_W(16)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .mode      (mode),
        .period    (period),
        .burst_len (burst_len),
        .threshold (threshold),
        .target    (target),
        .rnd       (rnd),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .inj_pulse (inj_pulse),
        .err_total (err_total),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // start pulse with in_valid low, then the ARM cycle; returns in RUN
    task automatic start_session(input logic [1:0] m, input logic [15:0] p,
                                 input logic [7:0] bl, input logic [7:0] th,
                                 input logic [15:0] tg);
        mode = m; period = p; burst_len = bl; threshold = th; target = tg;
        in_valid = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        mode = 2'b00; period = 16'd0; burst_len = 8'd0; threshold = 8'd0; target = 16'd0;
        chk("start_busy", busy, 1'b1);
        cyc();
    endtask

    initial begin
        int w;
        logic exp_err;
        reset = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'b00; period = 16'd0;
        burst_len = 8'd0; threshold = 8'd0; target = 16'd0; rnd = 8'd0;
        in_valid = 1'b0; in_data = 8'd0;
        #1 reset = 1'b1;
        #3;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_err_total", err_total, 16'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        @(negedge clock) reset = 1'b0;
        cyc();

        // periodic: period 4, target 3, rnd 5 -> mask 0x20
        rnd = 8'h05; in_data = 8'h00;
        start_session(2'b01, 16'd4, 8'd0, 8'd0, 16'd3);
        in_valid = 1'b1;
        for (int i = 1; i <= 13; i++) begin
            cyc();
            chk("per_data", out_data, (i % 4 == 0 && i <= 12) ? 8'h20 : 8'h00);
            chk("per_inj", inj_pulse, (i % 4 == 0 && i <= 12) ? 1'b1 : 1'b0);
            chk("per_done", done, (i == 12) ? 1'b1 : 1'b0);
            if (i == 8) chk("per_total8", err_total, 16'd2);
            if (i == 12) begin
                chk("per_total12", err_total, 16'd3);
                chk("per_busy12", busy, 1'b0);
            end
        end
        in_valid = 1'b0;

        // single with stalls
        start_session(2'b00, 16'd0, 8'd0, 8'd0, 16'd0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("sgl_stall_valid", out_valid, 1'b0);
            chk("sgl_stall_busy", busy, 1'b1);
        end
        in_valid = 1'b1; in_data = 8'hA5; rnd = 8'h03;
        cyc();
        chk("sgl_data", out_data, 8'hAD);
        chk("sgl_inj", inj_pulse, 1'b1);
        chk("sgl_done", done, 1'b1);
        chk("sgl_busy", busy, 1'b0);
        chk("sgl_total", err_total, 16'd1);
        cyc();
        chk("sgl_after_data", out_data, 8'hA5);
        chk("sgl_after_done", done, 1'b0);
        in_valid = 1'b0;

        // burst: period 2, len 3, unlimited; stalls must not shift the pattern
        in_data = 8'h0F; rnd = 8'h07;
        start_session(2'b11, 16'd2, 8'd3, 8'd0, 16'd0);
        w = 0;
        for (int s = 0; s < 13; s++) begin
            in_valid = !(s == 1 || s == 5 || s == 9);
            cyc();
            if (!(s == 1 || s == 5 || s == 9)) begin
                exp_err = (w % 5 >= 2);
                chk("bst_data", out_data, exp_err ? 8'h8F : 8'h0F);
                chk("bst_inj", inj_pulse, exp_err);
                w++;
            end else begin
                chk("bst_gap_valid", out_valid, 1'b0);
                chk("bst_gap_inj", inj_pulse, 1'b0);
            end
        end
        chk("bst_total", err_total, 16'd6);
        chk("bst_busy", busy, 1'b1);
        in_valid = 1'b1; abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("bst_abort_done", done, 1'b1);
        chk("bst_abort_inj", inj_pulse, 1'b0);
        chk("bst_abort_busy", busy, 1'b0);
        in_valid = 1'b0;

        // random: threshold 0x40
        in_data = 8'h00;
        start_session(2'b10, 16'd0, 8'd0, 8'h40, 16'd0);
        in_valid = 1'b1;
        rnd = 8'h10; cyc(); chk("rnd_w1", out_data, 8'h01);
        rnd = 8'h80; cyc(); chk("rnd_w2", out_data, 8'h00);
        rnd = 8'h3F; cyc(); chk("rnd_w3", out_data, 8'h80);
        rnd = 8'h40; cyc(); chk("rnd_w4", out_data, 8'h00);
        chk("rnd_total", err_total, 16'd2);
        abort = 1'b1; in_valid = 1'b0;
        cyc();
        abort = 1'b0;
        chk("rnd_abort_done", done, 1'b1);

        // abort during periodic period 1; start while busy ignored
        rnd = 8'h02;
        start_session(2'b01, 16'd1, 8'd0, 8'd0, 16'd0);
        in_valid = 1'b1;
        cyc(); chk("abt_w1", out_data, 8'h04);
        cyc(); chk("abt_w2", out_data, 8'h04);
        start = 1'b1; mode = 2'b00;
        cyc();
        start = 1'b0;
        chk("abt_restart_inj", inj_pulse, 1'b1);
        chk("abt_restart_total", err_total, 16'd3);
        chk("abt_restart_busy", busy, 1'b1);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("abt_word_clean", out_data, 8'h00);
        chk("abt_inj", inj_pulse, 1'b0);
        chk("abt_done", done, 1'b1);
        chk("abt_total", err_total, 16'd3);
        chk("abt_busy", busy, 1'b0);
        cyc();
        chk("abt_done_once", done, 1'b0);
        chk("abt_total_hold", err_total, 16'd3);

        // abort in IDLE, then start+abort together in IDLE
        abort = 1'b1;
        cyc();
        chk("idle_abort_done", done, 1'b0);
        start = 1'b1;
        cyc();
        start = 1'b0; abort = 1'b0;
        chk("sa_busy", busy, 1'b0);
        chk("sa_done", done, 1'b0);
        cyc();
        chk("sa_busy2", busy, 1'b0);
        in_valid = 1'b0;

        // reset mid-BURST
        rnd = 8'h00; in_data = 8'h00;
        start_session(2'b11, 16'd1, 8'd4, 8'd0, 16'd0);
        in_valid = 1'b1;
        cyc(); chk("mrst_gap_word", inj_pulse, 1'b0);
        cyc(); chk("mrst_burst_word", inj_pulse, 1'b1);
        reset = 1'b1;
        #2;
        chk("mrst_valid", out_valid, 1'b0);
        chk("mrst_inj", inj_pulse, 1'b0);
        chk("mrst_total", err_total, 16'd0);
        chk("mrst_busy", busy, 1'b0);
        in_valid = 1'b0;
        #2 reset = 1'b0;
        cyc();

        // fresh session after reset; period 0 acts as 1
        start_session(2'b01, 16'd0, 8'd0, 8'd0, 16'd2);
        in_valid = 1'b1;
        cyc();
        chk("fresh_w1", out_data, 8'h01);
        chk("fresh_total1", err_total, 16'd1);
        cyc();
        chk("fresh_w2", out_data, 8'h01);
        chk("fresh_total2", err_total, 16'd2);
        chk("fresh_done", done, 1'b1);
        chk("fresh_busy", busy, 1'b0);
        in_valid = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/err_inject_ctrl.md
Name: err_inject_ctrl

Overview:
- Sequences error insertion into the BERT transmit datapath.
- Owns the session state machine and decides which valid data words get corrupted: single, periodic, LFSR-random or burst.
- Corrupts a word by flipping one bit chosen from the free-running LFSR value.
- Sits between the PRBS/LFSR pattern source and the channel, and reports injected-error totals to the checker side.

Parameters:
- DATA_W, 8, width of data word and LFSR input.
- CNT_W, 16, width of period, target and error-count registers.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; latches config and begins a session when idle.
- abort  in  1  one-cycle pulse; ends the session immediately.
- mode  in  2  00 single, 01 periodic, 10 random, 11 burst; latched at start.
- period  in  CNT_W  words between injections (periodic) or gap before each burst (burst); latched.
- burst_len  in  8  consecutive corrupted words per burst; latched.
- threshold  in  DATA_W  random mode injects when rnd < threshold; latched.
- target  in  CNT_W  errors to inject before session completes; 0 = unlimited; latched.
- rnd  in  DATA_W  free-running LFSR value.
- in_valid  in  1  input word qualifier.
- in_data  in  DATA_W  clean pattern word.
- out_valid  out  1  registered in_valid.
- out_data  out  DATA_W  registered, possibly corrupted word.
- inj_pulse  out  1  high with the out_valid beat that carries an error.
- err_total  out  CNT_W  errors injected this session; saturating.
- busy  out  1  session active (ARM, RUN or BURST).
- done  out  1  one-cycle pulse on session completion or abort.

Behaviour:
- Reset: all outputs 0, FSM IDLE, internal counters 0, latched config 0.
- Datapath: fixed 1-cycle latency in every state. out_valid = in_valid delayed; out_data = in_data ^ mask, registered.
  - mask = 1 << (rnd mod DATA_W) on an inject beat, else 0.
  - Words pass clean whenever not injecting, including IDLE.
- IDLE:
  - start → latch config, clear err_total and word counter, go to ARM.
  - start while busy is ignored.
- ARM: one cycle, no injection; next state RUN.
  - Exception: mode 11 also goes to RUN, with the gap counter loaded to period.
- RUN, counts only valid words:
  - single: inject on the first valid word, then complete.
  - periodic: word counter increments per valid word; inject when the count reaches period, then reload to 0.
  - random: inject on any valid word with rnd < threshold.
  - burst: on gap expiry go to BURST. Gap expiry means period valid words seen with no injection.
- BURST: inject every valid word until burst_len of them are corrupted, then return to RUN with the gap reloaded.
- Clamping: period = 0 is treated as 1; burst_len = 0 is treated as 1.
- Stalls: in_valid low freezes all counters; no inject on invalid beats.
- err_total increments on each inject beat and saturates at all-ones.
- Completion: when target != 0 and err_total reaches target, go to IDLE in the same cycle as that last inject beat. done pulses, registered with the last out word.
- abort in any busy state → IDLE next cycle, with done pulsed.
  - abort has priority over an injection due the same cycle; that word passes clean.
  - abort in IDLE: no effect, no done.
- start and abort in the same cycle while IDLE: abort wins, no session.
- Reset mid-session: immediate return to reset values; out_valid drops asynchronously.
- Config inputs are ignored except at start.

Test Plan:
- Periodic: mode=01, period=4, target=3, in_valid constant high, in_data=8'h00, rnd=8'h05 → out_data=8'h20 on the 4th, 8th and 12th output words, others 8'h00; done pulses with the 12th; err_total=3.
- Single with stalls: mode=00, in_valid low for 5 cycles after start, then high → exactly one corrupted word (the first valid); busy low next cycle; err_total=1.
- Burst: mode=11, period=2, burst_len=3, target=0 → output pattern clean,clean,err,err,err repeating; in_valid gaps do not shift the pattern.
- Random: mode=10, threshold=8'h40, rnd stepped 0x10,0x80,0x3F,0x40 → injections on the 1st and 3rd words only.
- Abort: periodic period=1, abort asserted mid-session → the coincident word is clean, done pulses once, err_total holds, and start is ignored while busy.
- Reset mid-BURST: all outputs 0 immediately; a new start after release runs a fresh session with err_total starting from 0.
